sipo_register: RTL and testbench
================================

Name: sipo_register

Overview:
- Serial-in, parallel-out deserializer. It is the receive-side counterpart of the team's PISO register.
- Shifts in one bit per qualified clock and assembles WIDTH-bit words. Each completed word is presented on a registered parallel output with a valid/ready handshake.
- Includes bit counting, selectable bit order, a partial-word flush, and sticky overrun detection for when the downstream consumer stalls.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
- CNT_W, $clog2(WIDTH), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sin_valid  input  1  serial bit qualifier; sin is sampled only when 1.
- sin  input  1  serial data bit.
- clear  input  1  synchronous flush of the partial word and of overrun.
- dout  output  WIDTH  assembled parallel word (holding register).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- overrun  output  1  sticky: a completed word was dropped.
- bit_cnt  output  CNT_W  number of bits in the current partial word.

Behaviour:
- Reset (reset=0, asynchronous): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0. Release is synchronous to clk.
- Shift path, on an edge with sin_valid=1 and clear=0:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sh <= {sin, sh[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: an edge with sin_valid=1 and bit_cnt==WIDTH-1 completes a word (the word includes the current bit).
  - bit_cnt wraps to 0.
  - sh is cleared to 0.
  - The full word is loaded into dout at the same edge, so dout and dout_valid are visible in the cycle after the WIDTH-th bit is sampled.
  - Latency: 1 clock from the last bit to dout_valid=1.
- sin_valid=0: sh and bit_cnt hold. Gaps of any length between bits are legal.
- Output state machine:
  - EMPTY (dout_valid=0):
    - Completion -> FULL with the new word.
  - FULL (dout_valid=1): dout is stable until a handshake.
    - dout_ready=1 and no completion -> EMPTY. dout keeps its last value.
    - dout_ready=1 with completion in the same edge -> stays FULL; dout is replaced by the new word with no bubble.
    - dout_ready=0 with completion -> stays FULL; dout is unchanged; the new word is discarded; overrun <= 1.
- overrun: sticky. It is cleared only by reset or clear; the handshake does not clear it.
- clear=1 at an edge:
  - sh=0, bit_cnt=0, overrun=0.
  - Any sin sampled in the same edge is discarded; clear has priority over sin_valid.
  - dout and dout_valid are not affected, and a handshake in the same edge still completes normally.
- Reset mid-word or with dout_valid=1: all state returns to reset values immediately; the partial word and the pending output are lost.
- dout_ready while dout_valid=0: ignored.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=4, MSB_FIRST=1, dout_ready=1: sin_valid=1 on four consecutive edges with sin=1,0,1,1 -> one cycle after the 4th edge, dout=4'b1011 and dout_valid=1 for exactly 1 cycle; bit_cnt sequence 1,2,3,0.
- MSB_FIRST=0, same stimulus with 2-cycle gaps of sin_valid=0 between bits -> dout=4'b1101; bit_cnt holds during gaps; dout_valid=1 one cycle after the 4th bit.
- Back-pressure: dout_ready=0; send 1,0,1,1 then 0,1,1,0 -> dout stays 4'b1011, dout_valid stays 1, overrun=1 after the 8th bit. Then raise dout_ready for one cycle -> dout_valid=0, overrun remains 1 until clear is pulsed.
- Simultaneous: dout holds 4'b1011 with dout_valid=1; the 4th bit of 0,1,1,0 is sampled at the same edge as dout_ready=1 -> next cycle dout=4'b0110, dout_valid=1, overrun=0.
- Clear mid-word: after bits 1,1 (bit_cnt=2), pulse clear together with sin_valid=1, sin=1 -> bit_cnt=0 and that bit is dropped. The next 1,0,0,1 produces dout=4'b1001.
- Async reset: after bits 1,0,1 (bit_cnt=3) with dout_valid=1, drive reset=0 between clock edges -> dout=0, dout_valid=0, bit_cnt=0, overrun=0 immediately. After release, 0,0,1,1 produces dout=4'b0011.

Source files
------------

// File: rtl/sipo_register.sv
// Serial-in, parallel-out deserializer with a valid/ready output holding register,
// selectable bit order, synchronous flush and sticky overrun flag.
module sipo_register #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] dout_next;
  logic             accept;
  logic             complete;
  logic             overrun_next;
  state_t           state;
  state_t           state_next;

  // Shifted value including the current bit; also the completed word on the last bit.
  always_comb begin
    sh_next = sh;
    if (MSB_FIRST) begin
      sh_next = {sh[WIDTH-2:0], sin};
    end else begin
      sh_next = {sin, sh[WIDTH-1:1]};
    end
  end

  // Clear wins over a sampled bit, so a flushed edge never counts toward a word.
  always_comb begin
    accept   = sin_valid & ~clear;
    complete = accept & (bit_cnt == LAST_BIT);
  end

  // Partial-word shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clear || complete) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sh      <= sh_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Output state register with holding word and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      dout    <= dout_next;
      overrun <= overrun_next;
    end
  end

  // Next output state: load on completion, drain on handshake, drop the word when stalled.
  always_comb begin
    state_next   = state;
    dout_next    = dout;
    overrun_next = overrun;
    unique case (state)
      EMPTY: begin
        if (complete) begin
          state_next = FULL;
          dout_next  = sh_next;
        end
      end
      FULL: begin
        if (dout_ready) begin
          if (complete) begin
            dout_next = sh_next;
          end else begin
            state_next = EMPTY;
          end
        end else if (complete) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (clear) begin
      overrun_next = 1'b0;
    end
  end

  assign dout_valid = (state == FULL);

endmodule

// File: tb/tb_sipo_register.sv
// Bench for sipo_register: MSB-first and LSB-first instances driven in parallel
// through a vector table, hand-written reset sequence and a scoreboarded random run.
module tb_sipo_register;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset;
  logic          sin_valid;
  logic          sin;
  logic          clear;
  logic          dout_ready;
  logic [W-1:0]  dout_m, dout_l;
  logic          valid_m, valid_l;
  logic          ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  sipo_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin(sin), .clear(clear),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  sipo_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin(sin), .clear(clear),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sv;
    logic         s;
    logic         clr;
    logic         rdy;
    logic         ev;
    logic [W-1:0] edm;
    logic [W-1:0] edl;
    logic [CW-1:0] ec;
    logic         eo;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] l;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic sv, input logic s, input logic clr, input logic rdy,
                     input logic ev, input logic [W-1:0] edm, input logic [W-1:0] edl,
                     input logic [CW-1:0] ec, input logic eo);
    vec_t v;
    v.sv = sv; v.s = s; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.edm = edm; v.edl = edl; v.ec = ec; v.eo = eo;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic sv, input logic s, input logic clr, input logic rdy);
    @(negedge clk);
    sin_valid  = sv;
    sin        = s;
    clear      = clr;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [W-1:0] edm,
                           input logic [W-1:0] edl, input logic [CW-1:0] ec, input logic eo);
    chk({tag, ".valid_m"}, 32'(valid_m), 32'(ev));
    chk({tag, ".valid_l"}, 32'(valid_l), 32'(ev));
    chk({tag, ".dout_m"},  32'(dout_m),  32'(edm));
    chk({tag, ".dout_l"},  32'(dout_l),  32'(edl));
    chk({tag, ".cnt_m"},   32'(cnt_m),   32'(ec));
    chk({tag, ".cnt_l"},   32'(cnt_l),   32'(ec));
    chk({tag, ".ovr_m"},   32'(ovr_m),   32'(eo));
    chk({tag, ".ovr_l"},   32'(ovr_l),   32'(eo));
  endtask

  initial begin
    logic [W-1:0] am, al;
    int           mc;
    logic         pushed;
    logic         sv_r, s_r;
    exp_t         e;

    // sv s clr rdy | valid dout_msb dout_lsb cnt ovr
    // 1,0,1,1 back to back with consumer ready: valid for exactly one cycle
    add(1,1,0,1, 0,4'b0000,4'b0000,1,0);
    add(1,0,0,1, 0,4'b0000,4'b0000,2,0);
    add(1,1,0,1, 0,4'b0000,4'b0000,3,0);
    add(1,1,0,1, 1,4'b1011,4'b1101,0,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,0,0);
    // Same bits with two idle cycles between them: counter holds in gaps
    add(1,1,0,1, 0,4'b1011,4'b1101,1,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,1,0);
    add(0,1,0,1, 0,4'b1011,4'b1101,1,0);
    add(1,0,0,1, 0,4'b1011,4'b1101,2,0);
    add(0,1,0,1, 0,4'b1011,4'b1101,2,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,2,0);
    add(1,1,0,1, 0,4'b1011,4'b1101,3,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,3,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,3,0);
    add(1,1,0,1, 1,4'b1011,4'b1101,0,0);
    add(0,0,0,1, 0,4'b1011,4'b1101,0,0);
    // Back-pressure: second word dropped, overrun sticky across the handshake
    add(1,1,0,0, 0,4'b1011,4'b1101,1,0);
    add(1,0,0,0, 0,4'b1011,4'b1101,2,0);
    add(1,1,0,0, 0,4'b1011,4'b1101,3,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,0,0);
    add(1,0,0,0, 1,4'b1011,4'b1101,1,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,2,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,3,0);
    add(1,0,0,0, 1,4'b1011,4'b1101,0,1);
    add(0,0,0,0, 1,4'b1011,4'b1101,0,1);
    add(0,0,0,1, 0,4'b1011,4'b1101,0,1);
    add(0,0,0,0, 0,4'b1011,4'b1101,0,1);
    add(0,0,1,0, 0,4'b1011,4'b1101,0,0);
    // Completion coinciding with handshake: replace without a bubble
    add(1,1,0,0, 0,4'b1011,4'b1101,1,0);
    add(1,0,0,0, 0,4'b1011,4'b1101,2,0);
    add(1,1,0,0, 0,4'b1011,4'b1101,3,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,0,0);
    add(1,0,0,0, 1,4'b1011,4'b1101,1,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,2,0);
    add(1,1,0,0, 1,4'b1011,4'b1101,3,0);
    add(1,0,0,1, 1,4'b0110,4'b0110,0,0);
    add(0,0,0,1, 0,4'b0110,4'b0110,0,0);
    // Clear mid-word drops the coincident bit
    add(1,1,0,1, 0,4'b0110,4'b0110,1,0);
    add(1,1,0,1, 0,4'b0110,4'b0110,2,0);
    add(1,1,1,1, 0,4'b0110,4'b0110,0,0);
    add(1,1,0,1, 0,4'b0110,4'b0110,1,0);
    add(1,0,0,1, 0,4'b0110,4'b0110,2,0);
    add(1,0,0,1, 0,4'b0110,4'b0110,3,0);
    add(1,1,0,1, 1,4'b1001,4'b1001,0,0);
    add(0,0,0,1, 0,4'b1001,4'b1001,0,0);
    // Clear leaves the pending word alone; a handshake with clear still drains it
    add(1,1,0,0, 0,4'b1001,4'b1001,1,0);
    add(1,1,0,0, 0,4'b1001,4'b1001,2,0);
    add(1,1,0,0, 0,4'b1001,4'b1001,3,0);
    add(1,0,0,0, 1,4'b1110,4'b0111,0,0);
    add(1,1,0,0, 1,4'b1110,4'b0111,1,0);
    add(0,0,1,0, 1,4'b1110,4'b0111,0,0);
    add(0,0,1,1, 0,4'b1110,4'b0111,0,0);

    reset = 1'b0; sin_valid = 1'b0; sin = 1'b0; clear = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sv, vecs[i].s, vecs[i].clr, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].edm, vecs[i].edl, vecs[i].ec, vecs[i].eo);
    end

    // Asynchronous reset between edges with a pending word and a partial word
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,0); step(1,1,0,0);
    check_all("ar_full", 1'b1, 4'b1011, 4'b1101, 2'd0, 1'b0);
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,0);
    check_all("ar_part", 1'b1, 4'b1011, 4'b1101, 2'd3, 1'b0);
    #2;
    reset = 1'b0; sin_valid = 1'b0; sin = 1'b0;
    #1;
    check_all("ar_now", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1,0,0,1); step(1,0,0,1); step(1,1,0,1);
    check_all("ar_part2", 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
    step(1,1,0,1);
    check_all("ar_word", 1'b1, 4'b0011, 4'b1100, 2'd0, 1'b0);
    step(0,0,0,1);

    // Random stream with consumer always ready; expected words scored from a bit-level model
    am = '0; al = '0; mc = 0;
    for (int c = 0; c < 300; c++) begin
      sv_r = 1'($urandom_range(0, 1));
      s_r  = 1'($urandom_range(0, 1));
      pushed = 1'b0;
      if (sv_r) begin
        am = {am[W-2:0], s_r};
        al = {s_r, al[W-1:1]};
        mc++;
        if (mc == W) begin
          e.m = am; e.l = al;
          sb.push_back(e);
          pushed = 1'b1;
          mc = 0; am = '0; al = '0;
        end
      end
      step(sv_r, s_r, 1'b0, 1'b1);
      chk("rnd.cnt", 32'(cnt_m), 32'(mc));
      chk("rnd.valid", 32'(valid_m), 32'(pushed));
      chk("rnd.ovr", 32'(ovr_m), 32'd0);
      if (valid_m) begin
        if (sb.size() == 0) begin
          chk("rnd.unexpected_word", 32'(dout_m), 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("rnd.dout_m", 32'(dout_m), 32'(e.m));
          chk("rnd.dout_l", 32'(dout_l), 32'(e.l));
        end
      end
    end
    chk("rnd.sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
